// File: rtl/vector_mem_sequencer.sv
// Splits one VLEN-bit vector load/store into 32-bit XIF memory transactions.
// Optional alignment abort when VMS_MISALIGN_CHECK_EN is defined.
module vector_mem_sequencer #(
  parameter int VLEN       = 256,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_load_i,
  input  logic                  start_store_i,
  input  logic [31:0]           base_addr_i,
  input  logic [VLEN-1:0]       store_data_i,
  input  logic [X_ID_WIDTH-1:0] id_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [VLEN-1:0]       load_data_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  output logic [X_ID_WIDTH-1:0] mem_id_o,
  input  logic                  mem_exc_i,
  input  logic                  mem_result_valid_i,
  input  logic [31:0]           mem_result_rdata_i,
  input  logic                  mem_result_err_i
);

  localparam int NW = VLEN / 32;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RES = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]            state_q;
  logic [KW-1:0]         k_q;
  logic [31:0]           base_q;
  logic [VLEN-1:0]       sdata_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic                  we_q;
  logic                  err_q;
  logic [VLEN-1:0]       ldata_q;
  logic                  start;
  logic                  misalign;

  assign start = start_load_i | start_store_i;

`ifdef VMS_MISALIGN_CHECK_EN
  assign misalign = |base_addr_i[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      sdata_q <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ldata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr_i;
            sdata_q <= store_data_i;
            id_q    <= id_i;
            we_q    <= ~start_load_i;
            k_q     <= '0;
            err_q   <= misalign;
            if (start_load_i && !misalign)
              ldata_q <= '0;
            state_q <= misalign ? DONE : REQ;
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            if (mem_exc_i) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (mem_result_valid_i) begin
            if (!we_q)
              ldata_q[32*k_q +: 32] <= mem_result_rdata_i;
            if (mem_result_err_i) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (k_q == KW'(NW-1)) begin
              state_q <= DONE;
            end else begin
              k_q     <= k_q + KW'(1);
              state_q <= REQ;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = done_o & err_q;
  assign load_data_o = ldata_q;
  assign mem_valid_o = (state_q == REQ);
  assign mem_addr_o  = base_q + (32'(k_q) << 2);
  assign mem_we_o    = we_q;
  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = sdata_q[32*k_q +: 32];
  assign mem_id_o    = id_q;

endmodule
